// File: rtl/sram_dual_arbiter.sv
// rtl/sram_dual_arbiter.sv - round-robin arbiter sharing one pipelined-read SRAM between two ports
//
// Purpose:
//   Grants one of two requesters per cycle onto a single-port SRAM. Port 0 is
//   the CPU-side bridge; port 1 is the DMA / debug loader. Ties are broken
//   round-robin. A granted owner holding LOCK keeps the SRAM for up to
//   MAX_BURST consecutive grants while the other port waits; after that the
//   other port gets one grant. Read data returns one cycle after the grant and
//   is steered to the port that issued the read.
//
// Ports:
//   HCLK, HRESETn             clock (also clocks the SRAM), async active-low reset
//   REQx, LOCKx               request (held until granted), keep-grant hint
//   WRITEx, ADDRx, WDATAx     access direction, word address, write data
//   WSTRBx                    byte strobes, used on writes only
//   GNTx                      access accepted this cycle (combinational)
//   RVALIDx, RDATAx           read response, one cycle after the read grant
//   SRAM_CS/ADDR/WDATA/WREN   SRAM command, driven from the granted port
//   SRAM_RDATA                SRAM read data, one cycle after the address

module sram_dual_arbiter #(
  parameter int AW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          HCLK,
  input  logic          HRESETn,

  input  logic          REQ0,
  input  logic          LOCK0,
  input  logic          WRITE0,
  input  logic [AW-1:0] ADDR0,
  input  logic [31:0]   WDATA0,
  input  logic [3:0]    WSTRB0,
  output logic          GNT0,
  output logic          RVALID0,
  output logic [31:0]   RDATA0,

  input  logic          REQ1,
  input  logic          LOCK1,
  input  logic          WRITE1,
  input  logic [AW-1:0] ADDR1,
  input  logic [31:0]   WDATA1,
  input  logic [3:0]    WSTRB1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic [31:0]   RDATA1,

  output logic          SRAM_CS,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [31:0]   SRAM_WDATA,
  output logic [3:0]    SRAM_WREN,
  input  logic [31:0]   SRAM_RDATA
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // burst_cnt counts grants after the first one of a run, so a run may
  // continue while it is below MAX_BURST-1 (i.e. MAX_BURST grants total).
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [1:0] rd_pend_q, rd_pend_d;

  logic keep0, keep1;
  logic gnt0_raw, gnt1_raw;
  logic gnt0, gnt1;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // A locked owner only keeps priority while it was granted last cycle and
    // its run has not reached the cap. keep0/keep1 are exclusive by state.
    keep0 = (state_q == ST_OWN0) && LOCK0 && (burst_cnt_q < BURST_LIM);
    keep1 = (state_q == ST_OWN1) && LOCK1 && (burst_cnt_q < BURST_LIM);

    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    if (REQ0 && REQ1) begin
      if (keep0) begin
        gnt0_raw = 1'b1;
      end else if (keep1) begin
        gnt1_raw = 1'b1;
      end else if (rr_last_q) begin
        gnt0_raw = 1'b1;
      end else begin
        gnt1_raw = 1'b1;
      end
    end else begin
      // With a single requester LOCK is irrelevant: nobody is blocked.
      gnt0_raw = REQ0;
      gnt1_raw = REQ1;
    end
  end

  // Grants (and therefore the SRAM command) are forced off while reset is low.
  assign gnt0 = gnt0_raw & HRESETn;
  assign gnt1 = gnt1_raw & HRESETn;

  assign GNT0 = gnt0;
  assign GNT1 = gnt1;

  // ---------------------------------------------------------------------------
  // SRAM command mux
  // ---------------------------------------------------------------------------
  // Address and write data default to port 0 when idle; only CS/WREN qualify
  // the access, so there is no need to park them elsewhere.
  assign SRAM_CS    = gnt0 | gnt1;
  assign SRAM_ADDR  = gnt1 ? ADDR1  : ADDR0;
  assign SRAM_WDATA = gnt1 ? WDATA1 : WDATA0;

  always_comb begin
    SRAM_WREN = 4'b0000;
    if (gnt1) begin
      SRAM_WREN = WSTRB1 & {4{WRITE1}};
    end else if (gnt0) begin
      SRAM_WREN = WSTRB0 & {4{WRITE0}};
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  // rd_pend remembers which port issued last cycle's read; the SRAM output is
  // steered to that port only, the other port sees zero.
  assign RVALID0 = rd_pend_q[0];
  assign RVALID1 = rd_pend_q[1];
  assign RDATA0  = rd_pend_q[0] ? SRAM_RDATA : 32'h0;
  assign RDATA1  = rd_pend_q[1] ? SRAM_RDATA : 32'h0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = ST_IDLE;
    rr_last_d   = rr_last_q;
    burst_cnt_d = 8'd0;

    if (gnt0) begin
      state_d   = ST_OWN0;
      rr_last_d = 1'b0;
      if (state_q == ST_OWN0) begin
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
      end
    end else if (gnt1) begin
      state_d   = ST_OWN1;
      rr_last_d = 1'b1;
      if (state_q == ST_OWN1) begin
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
      end
    end

    rd_pend_d = {gnt1 & ~WRITE1, gnt0 & ~WRITE0};
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // rr_last resets to 1 so that port 0 wins the first tie after reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= 8'd0;
      rd_pend_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

endmodule
